// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve/rally/score FSM with ball and paddle motion.
// Optional macro PONG_SPEEDUP_EN: each paddle hit shortens the ball interval.
module pong_match_ctrl #(
  parameter int c_GAME_WIDTH    = 40,
  parameter int c_GAME_HEIGHT   = 30,
  parameter int c_PADDLE_HEIGHT = 6,
  parameter int c_BALL_FRAMES   = 2,
  parameter int c_PADDLE_FRAMES = 1,
  parameter int c_SERVE_FRAMES  = 60,
  parameter int c_WIN_SCORE     = 5
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic       i_Game_Start,
  input  logic       i_Paddle_Up_P1,
  input  logic       i_Paddle_Dn_P1,
  input  logic       i_Paddle_Up_P2,
  input  logic       i_Paddle_Dn_P2,
  output logic [6:0] o_Ball_X,
  output logic [5:0] o_Ball_Y,
  output logic [5:0] o_Paddle_Y_P1,
  output logic [5:0] o_Paddle_Y_P2,
  output logic [3:0] o_Score_P1,
  output logic [3:0] o_Score_P2,
  output logic [2:0] o_State,
  output logic [1:0] o_Winner
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RUN   = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [6:0] X_MID   = 7'(c_GAME_WIDTH / 2);
  localparam logic [5:0] Y_MID   = 6'(c_GAME_HEIGHT / 2);
  localparam logic [5:0] Y_MAX   = 6'(c_GAME_HEIGHT - 1);
  localparam logic [6:0] X_P2    = 7'(c_GAME_WIDTH - 2);
  localparam logic [5:0] PAD_MAX = 6'(c_GAME_HEIGHT - c_PADDLE_HEIGHT);
  localparam logic [5:0] PAD_MID =
    6'((c_GAME_HEIGHT - c_PADDLE_HEIGHT) / 2);
  localparam logic [6:0] PAD_SPAN = 7'(c_PADDLE_HEIGHT - 1);
  localparam logic [3:0] WIN     = 4'(c_WIN_SCORE);

  state_t      state_q, state_d;
  logic [6:0]  bx_q, bx_d;
  logic [5:0]  by_q, by_d;
  logic        dx_neg_q, dx_neg_d;
  logic        dy_neg_q, dy_neg_d;
  logic [5:0]  p1_q, p1_d;
  logic [5:0]  p2_q, p2_d;
  logic [3:0]  s1_q, s1_d;
  logic [3:0]  s2_q, s2_d;
  logic [1:0]  win_q, win_d;
  // Set when P1 conceded the last point: next serve heads toward P1.
  logic        serve_left_q, serve_left_d;
  logic [15:0] serve_cnt_q, serve_cnt_d;
  logic [15:0] ball_cnt_q, ball_cnt_d;
  logic [15:0] pad_cnt_q, pad_cnt_d;

  logic [15:0] ival;
  logic        hit;
  logic        serve_entry;
  logic        dy_n;
  logic        on_p1;
  logic        on_p2;

  assign on_p1 = ({1'b0, by_q} >= {1'b0, p1_q}) &&
                 ({1'b0, by_q} <= {1'b0, p1_q} + PAD_SPAN);
  assign on_p2 = ({1'b0, by_q} >= {1'b0, p2_q}) &&
                 ({1'b0, by_q} <= {1'b0, p2_q} + PAD_SPAN);

  function automatic logic [5:0] pad_step(
    input logic [5:0] p,
    input logic       up,
    input logic       dn
  );
    logic [5:0] r;
    r = p;
    if (up && !dn && p != 6'd0)
      r = p - 6'd1;
    else if (dn && !up && p < PAD_MAX)
      r = p + 6'd1;
    return r;
  endfunction

  always_comb begin
    state_d      = state_q;
    bx_d         = bx_q;
    by_d         = by_q;
    dx_neg_d     = dx_neg_q;
    dy_neg_d     = dy_neg_q;
    p1_d         = p1_q;
    p2_d         = p2_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    win_d        = win_q;
    serve_left_d = serve_left_q;
    serve_cnt_d  = serve_cnt_q;
    ball_cnt_d   = ball_cnt_q;
    pad_cnt_d    = pad_cnt_q;
    hit          = 1'b0;
    serve_entry  = 1'b0;
    dy_n         = dy_neg_q;

    if (state_q != S_IDLE && i_Frame_Tick) begin
      if (int'(pad_cnt_q) + 1 >= c_PADDLE_FRAMES) begin
        pad_cnt_d = '0;
        p1_d = pad_step(p1_q, i_Paddle_Up_P1, i_Paddle_Dn_P1);
        p2_d = pad_step(p2_q, i_Paddle_Up_P2, i_Paddle_Dn_P2);
      end else begin
        pad_cnt_d = pad_cnt_q + 16'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (i_Game_Start) begin
          state_d      = S_SERVE;
          s1_d         = '0;
          s2_d         = '0;
          serve_left_d = 1'b0;
        end
      end
      S_SERVE: begin
        if (i_Frame_Tick) begin
          if (int'(serve_cnt_q) + 1 >= c_SERVE_FRAMES)
            state_d = S_RUN;
          else
            serve_cnt_d = serve_cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (i_Frame_Tick) begin
          if (int'(ball_cnt_q) + 1 >= int'(ival)) begin
            ball_cnt_d = '0;
            if (by_q == 6'd0 && dy_neg_q)
              dy_n = 1'b0;
            else if (by_q == Y_MAX && !dy_neg_q)
              dy_n = 1'b1;
            dy_neg_d = dy_n;
            by_d = dy_n ? by_q - 6'd1 : by_q + 6'd1;
            if (bx_q == 7'd1 && dx_neg_q) begin
              if (on_p1) begin
                hit      = 1'b1;
                dx_neg_d = 1'b0;
                bx_d     = 7'd2;
              end else begin
                bx_d         = 7'd0;
                s2_d         = s2_q + 4'd1;
                serve_left_d = 1'b1;
                state_d      = S_POINT;
              end
            end else if (bx_q == X_P2 && !dx_neg_q) begin
              if (on_p2) begin
                hit      = 1'b1;
                dx_neg_d = 1'b1;
                bx_d     = X_P2 - 7'd1;
              end else begin
                bx_d         = X_P2 + 7'd1;
                s1_d         = s1_q + 4'd1;
                serve_left_d = 1'b0;
                state_d      = S_POINT;
              end
            end else begin
              bx_d = dx_neg_q ? bx_q - 7'd1 : bx_q + 7'd1;
            end
          end else begin
            ball_cnt_d = ball_cnt_q + 16'd1;
          end
        end
      end
      S_POINT: begin
        state_d = S_SERVE;
        if (!serve_left_q && s1_q == WIN) begin
          state_d = S_OVER;
          win_d   = 2'd1;
        end else if (serve_left_q && s2_q == WIN) begin
          state_d = S_OVER;
          win_d   = 2'd2;
        end
      end
      S_OVER: begin
        if (i_Game_Start) begin
          state_d      = S_SERVE;
          s1_d         = '0;
          s2_d         = '0;
          win_d        = 2'd0;
          serve_left_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      ball_cnt_d  = '0;
      pad_cnt_d   = '0;
      serve_cnt_d = '0;
    end
    if (state_d == S_SERVE && state_q != S_SERVE) begin
      serve_entry = 1'b1;
      bx_d        = X_MID;
      by_d        = Y_MID;
      dx_neg_d    = serve_left_d;
      dy_neg_d    = 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q      <= S_IDLE;
      bx_q         <= X_MID;
      by_q         <= Y_MID;
      dx_neg_q     <= 1'b0;
      dy_neg_q     <= 1'b0;
      p1_q         <= PAD_MID;
      p2_q         <= PAD_MID;
      s1_q         <= '0;
      s2_q         <= '0;
      win_q        <= '0;
      serve_left_q <= 1'b0;
      serve_cnt_q  <= '0;
      ball_cnt_q   <= '0;
      pad_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      dx_neg_q     <= dx_neg_d;
      dy_neg_q     <= dy_neg_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      win_q        <= win_d;
      serve_left_q <= serve_left_d;
      serve_cnt_q  <= serve_cnt_d;
      ball_cnt_q   <= ball_cnt_d;
      pad_cnt_q    <= pad_cnt_d;
    end
  end

`ifdef PONG_SPEEDUP_EN
  logic [15:0] ival_q, ival_d;

  always_comb begin
    ival_d = ival_q;
    if (serve_entry)
      ival_d = 16'(c_BALL_FRAMES);
    else if (hit && ival_q > 16'd1)
      ival_d = ival_q - 16'd1;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst)
      ival_q <= 16'(c_BALL_FRAMES);
    else
      ival_q <= ival_d;
  end

  assign ival = ival_q;
`else
  logic unused_speedup;
  assign unused_speedup = hit ^ serve_entry;
  assign ival = 16'(c_BALL_FRAMES);
`endif

  assign o_Ball_X      = bx_q;
  assign o_Ball_Y      = by_q;
  assign o_Paddle_Y_P1 = p1_q;
  assign o_Paddle_Y_P2 = p2_q;
  assign o_Score_P1    = s1_q;
  assign o_Score_P2    = s2_q;
  assign o_State       = state_q;
  assign o_Winner      = win_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Scenario bench for pong_match_ctrl: scripted rallies with hand-derived
// expected snapshots queued per stimulus step.
module tb_pong_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       up1 = 1'b0, dn1 = 1'b0, up2 = 1'b0, dn2 = 1'b0;
  logic [6:0] bx;
  logic [5:0] by, p1, p2;
  logic [3:0] s1, s2;
  logic [2:0] st;
  logic [1:0] win;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pong_match_ctrl dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Frame_Tick   (tick),
    .i_Game_Start   (start),
    .i_Paddle_Up_P1 (up1),
    .i_Paddle_Dn_P1 (dn1),
    .i_Paddle_Up_P2 (up2),
    .i_Paddle_Dn_P2 (dn2),
    .o_Ball_X       (bx),
    .o_Ball_Y       (by),
    .o_Paddle_Y_P1  (p1),
    .o_Paddle_Y_P2  (p2),
    .o_Score_P1     (s1),
    .o_Score_P2     (s2),
    .o_State        (st),
    .o_Winner       (win)
  );

  typedef struct packed {
    logic [2:0] st;
    logic [6:0] bx;
    logic [5:0] by;
    logic [5:0] p1;
    logic [5:0] p2;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
  } snap_t;

  // One scripted step: stimulus to apply, then the snapshot expected after it.
  typedef struct {
    string      name;
    bit         rst;
    bit         start;
    logic [3:0] btn;
    int         ticks;
    int         clks;
    snap_t      exp;
  } step_t;

  step_t sb[$];

  function automatic snap_t mk(int a, int x, int y, int q1, int q2,
                               int c1, int c2, int w);
    snap_t s;
    s.st = 3'(a);   s.bx = 7'(x);   s.by = 6'(y);
    s.p1 = 6'(q1);  s.p2 = 6'(q2);
    s.s1 = 4'(c1);  s.s2 = 4'(c2);  s.win = 2'(w);
    return s;
  endfunction

  function automatic void add(string n, bit r, bit go, logic [3:0] b,
                              int t, int c, snap_t e);
    step_t s;
    s.name = n; s.rst = r; s.start = go; s.btn = b;
    s.ticks = t; s.clks = c; s.exp = e;
    sb.push_back(s);
  endfunction

  function automatic snap_t observe();
    return {st, bx, by, p1, p2, s1, s2, win};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("st=%0d ball=(%0d,%0d) pad=%0d/%0d score=%0d/%0d win=%0d",
                     s.st, s.bx, s.by, s.p1, s.p2, s.s1, s.s2, s.win);
  endfunction

  // Each call leaves us at the negedge right after the tick's posedge.
  task automatic frame_tick();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic apply(input step_t s);
    if (s.rst) begin
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
    end
    if (s.start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    {up1, dn1, up2, dn2} = s.btn;
    repeat (s.ticks) frame_tick();
    repeat (s.clks) @(negedge clk);
  endtask

  task automatic test_reset();
    step_t s;
    snap_t got;
    add("reset", 1, 0, 4'b0000, 0, 0, mk(0, 20, 15, 12, 12, 0, 0, 0));
    add("idle_ignores_ticks", 0, 0, 4'b0110, 3, 0,
        mk(0, 20, 15, 12, 12, 0, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  task automatic test_serve();
    step_t s;
    snap_t got;
    add("start_to_serve", 0, 1, 4'b0000, 0, 0, mk(1, 20, 15, 12, 12, 0, 0, 0));
    add("serve_59", 0, 0, 4'b0000, 59, 0, mk(1, 20, 15, 12, 12, 0, 0, 0));
    add("start_ign_serve", 0, 1, 4'b0000, 0, 0, mk(1, 20, 15, 12, 12, 0, 0, 0));
    add("serve_60_run", 0, 0, 4'b0000, 1, 0, mk(2, 20, 15, 12, 12, 0, 0, 0));
    add("run_tick1", 0, 0, 4'b0000, 1, 0, mk(2, 20, 15, 12, 12, 0, 0, 0));
    add("run_step1", 0, 0, 4'b0000, 1, 0, mk(2, 21, 16, 12, 12, 0, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  task automatic test_p2_concede();
    step_t s;
    snap_t got;
    add("wall_bounce_step18", 0, 1, 4'b0000, 34, 0,
        mk(2, 38, 25, 12, 12, 0, 0, 0));
    add("half_interval", 0, 0, 4'b0000, 1, 0, mk(2, 38, 25, 12, 12, 0, 0, 0));
    add("p2_miss_point", 0, 0, 4'b0000, 1, 0, mk(3, 39, 24, 12, 12, 1, 0, 0));
    add("point_to_serve", 0, 0, 4'b0000, 0, 1, mk(1, 20, 15, 12, 12, 1, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  task automatic test_paddles();
    step_t s;
    snap_t got;
    add("p2_dn_saturate", 0, 0, 4'b0001, 40, 0,
        mk(1, 20, 15, 12, 24, 1, 0, 0));
    add("p2_up_dn_hold", 0, 0, 4'b0011, 5, 0, mk(1, 20, 15, 12, 24, 1, 0, 0));
    add("serve_done", 0, 0, 4'b0000, 15, 0, mk(2, 20, 15, 12, 24, 1, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  task automatic test_rally();
    step_t s;
    snap_t got;
    add("p2_hit", 0, 0, 4'b0000, 38, 0, mk(2, 37, 24, 12, 24, 1, 0, 0));
    add("top_bounce_to_p1", 0, 0, 4'b0000, 72, 0,
        mk(2, 1, 12, 12, 24, 1, 0, 0));
    add("p1_hit", 0, 0, 4'b0000, 2, 0, mk(2, 2, 13, 12, 24, 1, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  task automatic test_p1_concede();
    step_t s;
    snap_t got;
    add("p1_top_clamp", 0, 0, 4'b1010, 16, 0, mk(2, 10, 21, 0, 8, 1, 0, 0));
    add("to_p2_side", 0, 0, 4'b0000, 56, 0, mk(2, 38, 9, 0, 8, 1, 0, 0));
    add("p2_hit_edge", 0, 0, 4'b0000, 2, 0, mk(2, 37, 8, 0, 8, 1, 0, 0));
    add("to_p1_side", 0, 0, 4'b0000, 72, 0, mk(2, 1, 28, 0, 8, 1, 0, 0));
    add("p1_miss_point", 0, 0, 4'b0000, 2, 0, mk(3, 0, 29, 0, 8, 1, 1, 0));
    add("serve_again", 0, 0, 4'b0000, 0, 1, mk(1, 20, 15, 0, 8, 1, 1, 0));
    add("run_again", 0, 0, 4'b0000, 60, 0, mk(2, 20, 15, 0, 8, 1, 1, 0));
    add("serve_toward_p1", 0, 0, 4'b0000, 2, 0, mk(2, 19, 16, 0, 8, 1, 1, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  task automatic test_reset_midgame();
    step_t s;
    snap_t got;
    add("reset_in_run", 1, 0, 4'b0000, 0, 0, mk(0, 20, 15, 12, 12, 0, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  task automatic test_win();
    step_t s;
    snap_t got;
    add("win_start", 0, 1, 4'b0000, 0, 0, mk(1, 20, 15, 12, 12, 0, 0, 0));
    for (int k = 1; k <= 5; k++) begin
      add($sformatf("win_point%0d", k), 0, 0, 4'b0000, 98, 0,
          mk(3, 39, 24, 12, 12, k, 0, 0));
      if (k < 5)
        add($sformatf("win_serve%0d", k), 0, 0, 4'b0000, 0, 1,
            mk(1, 20, 15, 12, 12, k, 0, 0));
      else
        add("game_over", 0, 0, 4'b0000, 0, 1, mk(4, 39, 24, 12, 12, 5, 0, 1));
    end
    add("over_frozen", 0, 0, 4'b0100, 3, 0, mk(4, 39, 24, 15, 12, 5, 0, 1));
    add("over_restart", 0, 1, 4'b0000, 0, 0, mk(1, 20, 15, 15, 12, 0, 0, 0));
    while (sb.size() != 0) begin
      s = sb.pop_front();
      apply(s);
      got = observe();
      total++;
      if (got !== s.exp)
        $display("FAIL %s: got %s, want %s", s.name, fmt(got), fmt(s.exp));
      else
        passed++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_serve();
    test_p2_concede();
    test_paddles();
    test_rally();
    test_p1_concede();
    test_reset_midgame();
    test_win();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

Interface
REQ-001 Parameter c_GAME_WIDTH, default 40, playfield columns in tiles (range 8..128).
REQ-002 Parameter c_GAME_HEIGHT, default 30, playfield rows in tiles (range 8..64).
REQ-003 Parameter c_PADDLE_HEIGHT, default 6, paddle length in tiles (less than c_GAME_HEIGHT).
REQ-004 Parameter c_BALL_FRAMES, default 2, frame ticks per ball step (at least 1).
REQ-005 Parameter c_PADDLE_FRAMES, default 1, frame ticks per paddle step (at least 1).
REQ-006 Parameter c_SERVE_FRAMES, default 60, frame ticks spent in SERVE.
REQ-007 Parameter c_WIN_SCORE, default 5, points needed to win (range 1..15).
REQ-008 i_Clk  in  1  system clock; the block has one clock and reset is synchronous and active-high.
REQ-009 i_Rst  in  1  synchronous active-high reset.
REQ-010 i_Frame_Tick  in  1  single-cycle pulse, once per video frame.
REQ-011 i_Game_Start  in  1  single-cycle start request.
REQ-012 i_Paddle_Up_P1 / i_Paddle_Dn_P1 / i_Paddle_Up_P2 / i_Paddle_Dn_P2  in  1 each  debounced, level-held buttons.
REQ-013 o_Ball_X  out  7  ball column; o_Ball_Y  out  6  ball row.
REQ-014 o_Paddle_Y_P1 / o_Paddle_Y_P2  out  6 each  top row of each paddle.
REQ-015 o_Score_P1 / o_Score_P2  out  4 each  scores; o_State  out  3  state code; o_Winner  out  2  (0 none, 1 P1, 2 P2).

Function
REQ-016 States SHALL be IDLE=0, SERVE=1, RUNNING=2, POINT=3, GAME_OVER=4.
REQ-017 IDLE: i_Game_Start -> SERVE, scores 0; all other events are ignored.
REQ-018 SERVE: the ball is held at centre (c_GAME_WIDTH/2, c_GAME_HEIGHT/2); after c_SERVE_FRAMES frame ticks -> RUNNING.
REQ-019 Serve direction: +x toward P2 on the first serve, otherwise toward the player who conceded the last point; dy is always +1 on serve.
REQ-020 RUNNING: on every c_BALL_FRAMES-th frame tick the ball moves by (dx, dy), each in {-1, +1}; all updates occur in the cycle after the tick.
REQ-021 Wall bounce: if Y==0 with dy=-1, or Y==c_GAME_HEIGHT-1 with dy=+1, dy is negated before the step.
REQ-022 P1 side: at X==1 with dx=-1, if Y is within [Paddle_Y_P1, Paddle_Y_P1+c_PADDLE_HEIGHT-1] then dx:=+1 and X:=2; else X:=0, Score_P2 increments, state -> POINT.
REQ-023 P2 side: the mirror of REQ-022 at X==c_GAME_WIDTH-2, using Paddle_Y_P2 and Score_P1, with X:=c_GAME_WIDTH-3 on a hit.
REQ-024 Corner case: a wall bounce and a paddle bounce on the same step both apply.
REQ-025 POINT lasts one cycle: if the scorer's score equals c_WIN_SCORE -> GAME_OVER and o_Winner is set; else -> SERVE.
REQ-026 GAME_OVER: the ball and scores freeze; i_Game_Start clears scores and o_Winner -> SERVE.
REQ-027 i_Game_Start SHALL be ignored in SERVE, RUNNING and POINT.
REQ-028 Paddles move in every state except IDLE, one row per c_PADDLE_FRAMES frame ticks.
REQ-029 Paddle with Up only -> -1; Dn only -> +1; both or neither -> no move.
REQ-030 Paddle position clamps to [0, c_GAME_HEIGHT-c_PADDLE_HEIGHT]; a clamped paddle holds without wrapping.
REQ-031 The ball and paddle frame counters SHALL reset to 0 on each state entry, and a counter wraps to 0 on reaching its interval.

Reset
REQ-032 i_Rst, including mid-game, forces: IDLE, ball at centre, both paddles at (c_GAME_HEIGHT-c_PADDLE_HEIGHT)/2, scores 0, o_Winner 0, counters 0, dx=+1, dy=+1.

Configuration
REQ-033 Macro PONG_SPEEDUP_EN defined: each paddle hit decrements the current ball interval by 1, with a floor of 1; the interval reloads to c_BALL_FRAMES on every entry to SERVE.
REQ-034 PONG_SPEEDUP_EN undefined: the ball interval is fixed at c_BALL_FRAMES.

Verification
REQ-035 Reset, then the default parameters -> ball (20,15), paddles 12, scores 0, o_State 0.
REQ-036 i_Game_Start, then 60 ticks -> o_State 2; after 2 more ticks -> ball (21,16).
REQ-037 P1 paddle at 0, ball reaches X=1 with Y=20, dx=-1 -> next step: X=0, Score_P2=1, then SERVE with dx=-1.
REQ-038 P1 paddle at 12, ball at X=1, Y=14, dx=-1 -> X=2, dx=+1, no score.
REQ-039 Hold i_Paddle_Dn_P2 for 40 ticks -> o_Paddle_Y_P2 saturates at 24; Up and Dn held together -> unchanged.
REQ-040 Score_P1 reaches 5 -> o_State 4, o_Winner 1; i_Game_Start -> scores 0, o_State 1; i_Rst asserted in RUNNING -> the REQ-035 values.
